// File: rtl/controle_jogo_param.sv
// controle_jogo_param - parametrised game-control FSM for the chess-training datapath.
//
// Preloads N_SLOTS move memories at round start, regenerates the matched slot after a
// correct move, counts points/errors internally and ends the round on a point target,
// an error limit or timer expiry.
//
// Optional feature macro: CONTROLE_PAUSA_EN adds the `pausar` input and the PAUSA state
// (timer frozen, fimT ignored while paused).
//
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-low reset
//   iniciar, fimT, acertou,
//   temJogada, terminar       - control inputs from the datapath / player
//   slotAcerto [SLOT_W]       - slot matched by the player's move, sampled in REGISTRA
//   pausar                    - pause request (CONTROLE_PAUSA_EN only)
//   registraR .. numGerador   - single-cycle datapath strobes
//   numJogada [SLOT_W]        - memory slot addressed by the load/save strobes
//   vitoria, derrota          - round result flags
//   db_estado [4]             - debug state code
module controle_jogo_param #(
  parameter int unsigned N_SLOTS    = 3,
  parameter int unsigned SLOT_W     = 2,
  parameter int unsigned PONTOS_MAX = 8,
  parameter int unsigned ERROS_MAX  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              fimT,
  input  logic              acertou,
  input  logic              temJogada,
  input  logic              terminar,
  input  logic [SLOT_W-1:0] slotAcerto,
`ifdef CONTROLE_PAUSA_EN
  input  logic              pausar,
`endif
  output logic              registraR,
  output logic              zeraT,
  output logic              zeraR,
  output logic              zeraP,
  output logic              zeraG,
  output logic              contaP,
  output logic              contaT,
  output logic              decresceT,
  output logic              salvaNova,
  output logic              geraNova,
  output logic              numGerador,
  output logic [SLOT_W-1:0] numJogada,
  output logic              vitoria,
  output logic              derrota,
  output logic [3:0]        db_estado
);

  // State encoding equals the debug code so db_estado is a direct copy for legal states.
  typedef enum logic [3:0] {
    StInicial     = 4'h0,
    StIniciaElem  = 4'h1,
    StEspera      = 4'h2,
    StRegistra    = 4'h3,
    StCompara     = 4'h4,
    StResetGen    = 4'h5,
    StGera        = 4'h6,
    StSalva       = 4'h7,
    StCarrega     = 4'h8,
    StFimJogada   = 4'h9,
    StContaPonto  = 4'hA,
    StEsperaCarga = 4'hB,
`ifdef CONTROLE_PAUSA_EN
    StPausa       = 4'hC,
`endif
    StDecresce    = 4'hE,
    StFim         = 4'hF
  } state_e;

  localparam logic [SLOT_W-1:0] KLast = SLOT_W'(N_SLOTS - 1);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] k_q, k_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [7:0]        pts_q, pts_d;
  logic [7:0]        err_q, err_d;
  logic              vit_q, vit_d;
  logic              der_q, der_d;

  // State and internal registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StInicial;
      k_q     <= '0;
      slot_q  <= '0;
      pts_q   <= '0;
      err_q   <= '0;
      vit_q   <= 1'b0;
      der_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      slot_q  <= slot_d;
      pts_q   <= pts_d;
      err_q   <= err_d;
      vit_q   <= vit_d;
      der_q   <= der_d;
    end
  end

  // Next state and register updates.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    slot_d  = slot_q;
    pts_d   = pts_q;
    err_d   = err_q;
    vit_d   = vit_q;
    der_d   = der_q;
    case (state_q)
      StInicial: begin
        pts_d = '0;
        err_d = '0;
        vit_d = 1'b0;
        der_d = 1'b0;
        if (iniciar) state_d = StIniciaElem;
      end
      StIniciaElem: begin
        k_d     = '0;
        state_d = StCarrega;
      end
      StCarrega:     state_d = (k_q == KLast) ? StEspera : StEsperaCarga;
      StEsperaCarga: begin
        k_d     = k_q + SLOT_W'(1);
        state_d = StCarrega;
      end
      StEspera: begin
        if (fimT) begin
          state_d = StFim;
          if (!vit_q) der_d = 1'b1;
        end
`ifdef CONTROLE_PAUSA_EN
        else if (pausar) state_d = StPausa;
`endif
        else if (temJogada) state_d = StRegistra;
      end
      StRegistra: begin
        slot_d  = slotAcerto;
        state_d = StCompara;
      end
      StCompara:    state_d = acertou ? StContaPonto : StDecresce;
      StContaPonto: begin
        if (pts_q != 8'hFF) pts_d = pts_q + 8'd1;
        if (PONTOS_MAX != 0 && (32'(pts_q) + 32'd1) == PONTOS_MAX) begin
          state_d = StFim;
          if (!der_q) vit_d = 1'b1;
        end else begin
          state_d = StGera;
        end
      end
      StGera:     state_d = StSalva;
      StSalva:    state_d = StFimJogada;
      StDecresce: begin
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
        if (ERROS_MAX != 0 && (32'(err_q) + 32'd1) == ERROS_MAX) begin
          state_d = StFim;
          if (!vit_q) der_d = 1'b1;
        end else begin
          state_d = StFimJogada;
        end
      end
      StFimJogada: state_d = StEspera;
      StFim: begin
        // Clear on the way out so INICIAL already shows clean flags.
        if (terminar) begin
          state_d = StInicial;
          pts_d   = '0;
          err_d   = '0;
          vit_d   = 1'b0;
          der_d   = 1'b0;
        end
      end
      StResetGen: state_d = StInicial;
`ifdef CONTROLE_PAUSA_EN
      StPausa: if (!pausar) state_d = StEspera;
`endif
      default: state_d = StResetGen;
    endcase
  end

  // Moore outputs.
  always_comb begin
    registraR  = 1'b0;
    zeraT      = 1'b0;
    zeraR      = 1'b0;
    zeraP      = 1'b0;
    zeraG      = 1'b0;
    contaP     = 1'b0;
    contaT     = 1'b1;
    decresceT  = 1'b0;
    salvaNova  = 1'b0;
    geraNova   = 1'b0;
    numGerador = 1'b0;
    numJogada  = '0;
    db_estado  = state_q;
    case (state_q)
      StInicial: begin
        zeraR  = 1'b1;
        contaT = 1'b0;
      end
      StIniciaElem: begin
        zeraT    = 1'b1;
        zeraP    = 1'b1;
        geraNova = 1'b1;
        contaT   = 1'b0;
      end
      StCarrega: begin
        salvaNova = 1'b1;
        numJogada = k_q;
        contaT    = 1'b0;
      end
      StEsperaCarga: begin
        geraNova  = 1'b1;
        numJogada = k_q + SLOT_W'(1);
        contaT    = 1'b0;
      end
      StEspera, StCompara, StFimJogada: ;
      StRegistra:   registraR = 1'b1;
      StContaPonto: contaP    = 1'b1;
      StGera: begin
        geraNova   = 1'b1;
        numGerador = 1'b1;
        numJogada  = slot_q;
      end
      StSalva: begin
        salvaNova  = 1'b1;
        numGerador = 1'b1;
        numJogada  = slot_q;
      end
      StDecresce: decresceT = 1'b1;
      StFim:      contaT    = 1'b0;
      StResetGen: begin
        zeraG  = 1'b1;
        contaT = 1'b0;
      end
`ifdef CONTROLE_PAUSA_EN
      StPausa: contaT = 1'b0;
`endif
      default: db_estado = 4'hD;
    endcase
  end

  assign vitoria = vit_q;
  assign derrota = der_q;

endmodule

// File: tb/tb_controle_jogo_param.sv
module tb_controle_jogo_param;
  localparam int unsigned NS = 4;
  localparam int unsigned SW = 2;

  // Input bundle order: {reset, iniciar, fimT, acertou, temJogada, terminar, pausar}
  localparam logic [6:0] IDLE = 7'b1000000;
  localparam logic [6:0] INI  = 7'b1100000;
  localparam logic [6:0] FIMT = 7'b1010000;
  localparam logic [6:0] AC   = 7'b1001000;
  localparam logic [6:0] TJ   = 7'b1000100;
  localparam logic [6:0] TERM = 7'b1000010;
  localparam logic [6:0] PAU  = 7'b1000001;
  localparam logic [6:0] RST  = 7'b0000000;

  logic clock = 1'b0;
  logic reset, iniciar, fimT, acertou, temJogada, terminar;
  logic [SW-1:0] slotAcerto;
`ifdef CONTROLE_PAUSA_EN
  logic pausar;
`endif
  logic registraR, zeraT, zeraR, zeraP, zeraG, contaP, contaT, decresceT;
  logic salvaNova, geraNova, numGerador, vitoria, derrota;
  logic [SW-1:0] numJogada;
  logic [3:0] db_estado;

  controle_jogo_param #(
    .N_SLOTS(NS), .SLOT_W(SW), .PONTOS_MAX(2), .ERROS_MAX(3)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fimT(fimT), .acertou(acertou),
    .temJogada(temJogada), .terminar(terminar), .slotAcerto(slotAcerto),
`ifdef CONTROLE_PAUSA_EN
    .pausar(pausar),
`endif
    .registraR(registraR), .zeraT(zeraT), .zeraR(zeraR), .zeraP(zeraP), .zeraG(zeraG),
    .contaP(contaP), .contaT(contaT), .decresceT(decresceT), .salvaNova(salvaNova),
    .geraNova(geraNova), .numGerador(numGerador), .numJogada(numJogada),
    .vitoria(vitoria), .derrota(derrota), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0]    in;
    logic [SW-1:0] slot;
    logic [3:0]    st;
    logic [SW-1:0] nj;
    logic          v;
    logic          d;
  } item_t;

  typedef struct packed {
    logic [3:0]    st;
    logic [SW-1:0] nj;
    logic          v;
    logic          d;
  } exp_t;

  item_t stim_q[$];
  exp_t  exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [18:0] obs;
  assign obs = {db_estado, zeraR, zeraT, zeraP, zeraG, registraR, contaP, contaT, decresceT,
                salvaNova, geraNova, numGerador, numJogada, vitoria, derrota};

  // Strobe pattern per state code, taken from the state table:
  // {zeraR,zeraT,zeraP,zeraG,registraR,contaP,contaT,decresceT,salvaNova,geraNova,numGerador}
  function automatic logic [10:0] strobes(input logic [3:0] st);
    case (st)
      4'h0: return 11'b10000000000;
      4'h1: return 11'b01100000010;
      4'h8: return 11'b00000000100;
      4'hB: return 11'b00000000010;
      4'h3: return 11'b00001010000;
      4'hA: return 11'b00000110000;
      4'h6: return 11'b00000010011;
      4'h7: return 11'b00000010101;
      4'hE: return 11'b00000011000;
      4'h5: return 11'b00010000000;
      4'hC, 4'hF: return 11'b00000000000;
      default: return 11'b00000010000;
    endcase
  endfunction

  function automatic logic [18:0] exp_vec(input exp_t e);
    return {e.st, strobes(e.st), e.nj, e.v, e.d};
  endfunction

  function automatic item_t mk(input logic [6:0] in, input logic [SW-1:0] slot,
                               input logic [3:0] st, input logic [SW-1:0] nj,
                               input logic v, input logic d);
    item_t it;
    it.in = in; it.slot = slot; it.st = st; it.nj = nj; it.v = v; it.d = d;
    return it;
  endfunction

  // Apply one cycle of stimulus, queue its expected outcome, sample after the edge.
  task automatic drive(input item_t it);
    exp_t e;
    {reset, iniciar, fimT, acertou, temJogada, terminar} = it.in[6:1];
`ifdef CONTROLE_PAUSA_EN
    pausar = it.in[0];
`endif
    slotAcerto = it.slot;
    e.st = it.st; e.nj = it.nj; e.v = it.v; e.d = it.d;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Queue a full preload from INICIAL: INICIA_ELEM, then CARREGA/ESPERA_CARGA pairs, ESPERA.
  task automatic push_preload();
    stim_q.push_back(mk(INI, 0, 4'h1, 0, 0, 0));
    for (int j = 0; j < NS; j++) begin
      stim_q.push_back(mk(IDLE, 0, 4'h8, SW'(j), 0, 0));
      if (j < NS - 1) stim_q.push_back(mk(IDLE, 0, 4'hB, SW'(j + 1), 0, 0));
    end
    stim_q.push_back(mk(IDLE, 0, 4'h2, 0, 0, 0));
  endtask

  task automatic test_reset();
    exp_t e;
    stim_q.push_back(mk(RST, 0, 4'h0, 0, 0, 0));
    stim_q.push_back(mk(RST, 0, 4'h0, 0, 0, 0));
    stim_q.push_back(mk(IDLE, 0, 4'h0, 0, 0, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL test_reset: got %h want %h", obs, exp_vec(e));
      end
    end
  endtask

  task automatic test_preload();
    exp_t e;
    push_preload();
    stim_q.push_back(mk(IDLE, 0, 4'h2, 0, 0, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL test_preload: got %h want %h", obs, exp_vec(e));
      end
    end
  endtask

  // First correct move (pts 0 -> 1, below target): full regeneration of slot 2.
  task automatic test_correct();
    exp_t e;
    stim_q.push_back(mk(TJ,   2, 4'h3, 0, 0, 0));
    stim_q.push_back(mk(IDLE, 2, 4'h4, 0, 0, 0));
    stim_q.push_back(mk(AC,   0, 4'hA, 0, 0, 0));
    stim_q.push_back(mk(IDLE, 0, 4'h6, 2, 0, 0));
    stim_q.push_back(mk(IDLE, 0, 4'h7, 2, 0, 0));
    stim_q.push_back(mk(IDLE, 0, 4'h9, 0, 0, 0));
    stim_q.push_back(mk(IDLE, 0, 4'h2, 0, 0, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL test_correct: got %h want %h", obs, exp_vec(e));
      end
    end
  endtask

  // Second correct move reaches PONTOS_MAX=2: straight to FIM, no GERA.
  task automatic test_win();
    exp_t e;
    stim_q.push_back(mk(TJ,   1, 4'h3, 0, 0, 0));
    stim_q.push_back(mk(IDLE, 1, 4'h4, 0, 0, 0));
    stim_q.push_back(mk(AC,   0, 4'hA, 0, 0, 0));
    stim_q.push_back(mk(IDLE, 0, 4'hF, 0, 1, 0));
    stim_q.push_back(mk(IDLE, 0, 4'hF, 0, 1, 0));
    stim_q.push_back(mk(TERM, 0, 4'h0, 0, 0, 0));
    stim_q.push_back(mk(IDLE, 0, 4'h0, 0, 0, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL test_win: got %h want %h", obs, exp_vec(e));
      end
    end
  endtask

  // Three wrong moves with ERROS_MAX=3; fimT during REGISTRA must be ignored.
  task automatic test_errors();
    exp_t e;
    push_preload();
    for (int m = 0; m < 3; m++) begin
      stim_q.push_back(mk(TJ, 0, 4'h3, 0, 0, 0));
      stim_q.push_back(mk((m == 0) ? FIMT : IDLE, 0, 4'h4, 0, 0, 0));
      stim_q.push_back(mk(IDLE, 0, 4'hE, 0, 0, 0));
      if (m < 2) begin
        stim_q.push_back(mk(IDLE, 0, 4'h9, 0, 0, 0));
        stim_q.push_back(mk(IDLE, 0, 4'h2, 0, 0, 0));
      end else begin
        stim_q.push_back(mk(IDLE, 0, 4'hF, 0, 0, 1));
      end
    end
    stim_q.push_back(mk(IDLE, 0, 4'hF, 0, 0, 1));
    stim_q.push_back(mk(TERM, 0, 4'h0, 0, 0, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL test_errors: got %h want %h", obs, exp_vec(e));
      end
    end
  endtask

  // fimT and temJogada together in ESPERA: fimT wins, no REGISTRA.
  task automatic test_fimt_priority();
    exp_t e;
    push_preload();
    stim_q.push_back(mk(FIMT | TJ, 0, 4'hF, 0, 0, 1));
    stim_q.push_back(mk(IDLE,      0, 4'hF, 0, 0, 1));
    stim_q.push_back(mk(TERM,      0, 4'h0, 0, 0, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL test_fimt_priority: got %h want %h", obs, exp_vec(e));
      end
    end
  endtask

  // Reset asserted while in CARREGA abandons the preload.
  task automatic test_reset_mid_load();
    exp_t e;
    stim_q.push_back(mk(INI,  0, 4'h1, 0, 0, 0));
    stim_q.push_back(mk(IDLE, 0, 4'h8, 0, 0, 0));
    stim_q.push_back(mk(IDLE, 0, 4'hB, 1, 0, 0));
    stim_q.push_back(mk(IDLE, 0, 4'h8, 1, 0, 0));
    stim_q.push_back(mk(RST,  0, 4'h0, 0, 0, 0));
    stim_q.push_back(mk(IDLE, 0, 4'h0, 0, 0, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL test_reset_mid_load: got %h want %h", obs, exp_vec(e));
      end
    end
  endtask

`ifdef CONTROLE_PAUSA_EN
  task automatic test_pause();
    exp_t e;
    push_preload();
    stim_q.push_back(mk(PAU,        0, 4'hC, 0, 0, 0));
    stim_q.push_back(mk(PAU | FIMT, 0, 4'hC, 0, 0, 0));
    stim_q.push_back(mk(IDLE,       0, 4'h2, 0, 0, 0));
    stim_q.push_back(mk(IDLE,       0, 4'h2, 0, 0, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL test_pause: got %h want %h", obs, exp_vec(e));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_preload();
    test_correct();
    test_win();
    test_errors();
    test_fimt_priority();
    test_reset_mid_load();
`ifdef CONTROLE_PAUSA_EN
    test_pause();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
